// File: rtl/mult_div_sequencer_if.sv
// Request/result bus of the iterative multiply/divide sequencer.
// The master drives the request; the slave (the sequencer) returns status and HI/LO.
interface mult_div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, funct, op_a, op_b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, funct, op_a, op_b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative MIPS-style mult/multu/div/divu unit: shift-add multiply and restoring divide on magnitudes.
// Define MULDIV_SIGNED_EN to make funct 24/26 signed; otherwise all four ops are unsigned.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clock_i,
    input  logic                reset_i,
    mult_div_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             is_signed_q, is_signed_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] lower_q, lower_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic               accept;
    logic               neg_a, neg_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept = bus.start
                 && (bus.funct inside {6'd24, 6'd25, 6'd26, 6'd27})
                 && (state_q == S_IDLE || state_q == S_DONE);

    assign neg_a = is_signed_q & a_q[WIDTH-1];
    assign neg_b = is_signed_q & b_q[WIDTH-1];

    // Multiply keeps {upper, lower} as {partial product, remaining multiplier bits}.
    assign add_sum   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, mag_b_q} : '0);
    // Divide keeps {upper, lower} as {partial remainder, dividend bits becoming quotient bits}.
    assign rem_shift = {upper_q, lower_q[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, mag_b_q};
    assign rem_diff  = rem_shift[WIDTH-1:0] - mag_b_q;

    assign prod_raw = {upper_q, lower_q};
    assign prod_fix = (neg_a ^ neg_b) ? -prod_raw : prod_raw;
    assign quo_fix  = (neg_a ^ neg_b) ? -lower_q : lower_q;
    assign rem_fix  = neg_a ? -upper_q : upper_q;

    always_comb begin
        // NOTE: every _d takes its current value first, so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        a_d         = a_q;
        b_d         = b_q;
        mag_b_d     = mag_b_q;
        upper_d     = upper_q;
        lower_d     = lower_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = bus.funct[1];
`ifdef MULDIV_SIGNED_EN
                    is_signed_d = ~bus.funct[0];
`else
                    is_signed_d = 1'b0;
`endif
                    a_d   = bus.op_a;
                    b_d   = bus.op_b;
                    dbz_d = 1'b0;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == '0) begin
                    // First CALC cycle loads magnitudes; the next WIDTH cycles iterate.
                    upper_d = '0;
                    lower_d = neg_a ? -a_q : a_q;
                    mag_b_d = neg_b ? -b_q : b_q;
                end else if (is_div_q) begin
                    upper_d = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                    lower_d = {lower_q[WIDTH-2:0], rem_ge};
                end else begin
                    upper_d = add_sum[WIDTH:1];
                    lower_d = {add_sum[0], lower_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (mag_b_q == '0) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mag_b_q     <= '0;
            upper_q     <= '0;
            lower_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            dbz_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mag_b_q     <= mag_b_d;
            upper_q     <= upper_d;
            lower_q     <= lower_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done        = (state_q == S_DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed vector table, multi-cycle corner
// sequences, and random operations against an arithmetic reference model.
module tb_mult_div_sequencer;
    localparam int W   = 32;
    localparam int LAT = W + 2;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       name;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    mult_div_sequencer_if #(.WIDTH(W)) bus ();

    mult_div_sequencer #(.WIDTH(W)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign- or zero-extended operands.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        bit          sgn;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sgn = SIGNED_EN && (f == 6'd24 || f == 6'd26);
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        dbz = 1'b0;
        if (f == 6'd24 || f == 6'd25) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dbz = 1'b1;
            hi  = a;
            lo  = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; the request is taken on the next rising edge.
    task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.funct = f;
        bus.op_a  = a;
        bus.op_b  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                             output int lat, output int busy_n);
        hi     = 'x;
        lo     = 'x;
        dbz    = 1'bx;
        lat    = -1;
        busy_n = bus.busy ? 1 : 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                hi  = bus.hi;
                lo  = bus.lo;
                dbz = bus.div_by_zero;
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                          output int lat, output int busy_n);
        @(negedge clk);
        launch(f, a, b);
        wait_done(hi, lo, dbz, lat, busy_n);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] g_hi, g_lo, e_hi, e_lo;
        logic        g_dbz, e_dbz;
        int          lat, busy_n, dones, first_lat;
        logic [5:0]  f;
        logic [31:0] a, b;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_dbz", bus.div_by_zero, 0);

        // Unsupported funct codes are ignored.
        @(negedge clk);
        launch(6'd0, 32'd5, 32'd5);
        check("bad_funct0_busy", bus.busy, 0);
        launch(6'd28, 32'd5, 32'd5);
        check("bad_funct28_busy", bus.busy, 0);

        vecs.push_back('{6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max"});
        vecs.push_back('{6'd24, 32'hFFFF_FFFD, 32'd7, SIGNED_EN ? 32'hFFFF_FFFF : 32'd6, 32'hFFFF_FFEB, 1'b0, "mult_m3x7"});
        vecs.push_back('{6'd27, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7"});
        vecs.push_back('{6'd26, 32'hFFFF_FFF9, 32'd2, SIGNED_EN ? 32'hFFFF_FFFF : 32'd1,
                         SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0, "div_m7_2"});
        vecs.push_back('{6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "divu_5_0"});
        vecs.push_back('{6'd25, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "multu_2x3"});
        vecs.push_back('{6'd26, 32'h8000_0000, 32'hFFFF_FFFF, SIGNED_EN ? 32'd0 : 32'h8000_0000,
                         SIGNED_EN ? 32'h8000_0000 : 32'd0, 1'b0, "div_min_m1"});
        vecs.push_back('{6'd26, 32'd7, 32'hFFFF_FFFE, SIGNED_EN ? 32'd1 : 32'd7,
                         SIGNED_EN ? 32'hFFFF_FFFD : 32'd0, 1'b0, "div_7_m2"});
        vecs.push_back('{6'd26, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_m7_0"});
        vecs.push_back('{6'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, SIGNED_EN ? 32'd0 : 32'hFFFF_FFFE, 32'd1, 1'b0, "mult_m1xm1"});

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, g_hi, g_lo, g_dbz, lat, busy_n);
            check({vecs[i].name, "_lat"}, lat, LAT);
            check({vecs[i].name, "_busy_cycles"}, busy_n, LAT);
            check({vecs[i].name, "_hi"}, g_hi, vecs[i].hi);
            check({vecs[i].name, "_lo"}, g_lo, vecs[i].lo);
            check({vecs[i].name, "_dbz"}, g_dbz, vecs[i].dbz);
            @(negedge clk);
            check({vecs[i].name, "_done_falls"}, bus.done, 0);
            check({vecs[i].name, "_hi_held"}, bus.hi, vecs[i].hi);
            check({vecs[i].name, "_dbz_held"}, bus.div_by_zero, vecs[i].dbz);
        end

        // New request accepted in the DONE cycle.
        run_op(6'd25, 32'd2, 32'd3, g_hi, g_lo, g_dbz, lat, busy_n);
        check("b2b_first_lo", g_lo, 6);
        launch(6'd27, 32'd100, 32'd7);
        check("b2b_done_falls", bus.done, 0);
        check("b2b_busy", bus.busy, 1);
        wait_done(g_hi, g_lo, g_dbz, lat, busy_n);
        check("b2b_lat", lat, LAT);
        check("b2b_lo", g_lo, 14);
        check("b2b_hi", g_hi, 2);

        // Start while busy is ignored.
        @(negedge clk);
        launch(6'd25, 32'd2, 32'd3);
        dones     = 0;
        first_lat = -1;
        g_lo      = 'x;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bus.start = (k == 10);
            if (k == 10) begin
                bus.funct = 6'd25;
                bus.op_a  = 32'd9;
                bus.op_b  = 32'd3;
            end
            if (bus.done) begin
                dones++;
                if (first_lat < 0) begin
                    first_lat = k;
                    g_lo      = bus.lo;
                end
            end
        end
        bus.start = 1'b0;
        check("busy_start_lat", first_lat, LAT);
        check("busy_start_lo", g_lo, 6);
        check("busy_start_done_count", dones, 1);

        // Reset mid-divide aborts without a done pulse.
        @(negedge clk);
        launch(6'd27, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(6'd27, 32'd9, 32'd3, g_hi, g_lo, g_dbz, lat, busy_n);
        check("after_abort_lat", lat, LAT);
        check("after_abort_lo", g_lo, 3);
        check("after_abort_hi", g_hi, 0);

        // Reset wins over a same-edge start.
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.funct = 6'd25;
        bus.op_a  = 32'd2;
        bus.op_b  = 32'd3;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_prio_busy", bus.busy, 0);
        @(negedge clk);
        check("rst_prio_busy_later", bus.busy, 0);
        check("rst_prio_lo", bus.lo, 0);

        for (int n = 0; n < 150; n++) begin
            f = 6'(24 + $urandom_range(0, 3));
            a = pick_val();
            b = pick_val();
            model(f, a, b, e_hi, e_lo, e_dbz);
            run_op(f, a, b, g_hi, g_lo, g_dbz, lat, busy_n);
            check($sformatf("rand%0d_f%0d_lat", n, f), lat, LAT);
            check($sformatf("rand%0d_f%0d_a%h_b%h_hi", n, f, a, b), g_hi, e_hi);
            check($sformatf("rand%0d_f%0d_a%h_b%h_lo", n, f, a, b), g_lo, e_lo);
            check($sformatf("rand%0d_f%0d_dbz", n, f), g_dbz, e_dbz);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
